uart_tx: RTL and testbench

//  Serialises parallel bytes into asynchronous UART frames on a single tx line.

---
 rtl/uart_tx.sv | 126 ++++++++++++
 tb/tb_uart_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: turns parallel bytes into asynchronous UART frames on one serial line.
// Frame on the line: start(0), DATA_WIDTH data bits LSB first, optional parity,
// then STOP_BITS stop bits(1). Every bit lasts CLOCK_BAUD_RATIO clk cycles.
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset, aborts any frame in flight
//   valid - upstream offers a byte on data
//   ready - block accepts a byte this cycle (IDLE and not in reset)
//   data  - byte to send, captured only on the accept cycle
//   tx    - serial line, registered, idles high
//   busy  - high while a frame is on the line
module uart_tx #(
  parameter int CLOCK_BAUD_RATIO = 400,
  parameter int DATA_WIDTH       = 8,
  parameter int PARITY_EN        = 1,
  parameter int PARITY_ODD       = 1,
  parameter int STOP_BITS        = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  output logic                  ready,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  tx,
  output logic                  busy
);

  localparam int BW = $clog2(CLOCK_BAUD_RATIO);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCK_BAUD_RATIO - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_n;
  logic [BW-1:0]         baud, baud_n;
  logic [CW-1:0]         bitc, bitc_n;   // data bit index, reused as stop bit index
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic                  par, par_n;     // parity bit, fixed at accept time
  logic                  tx_d;
  logic                  bit_end;

  assign bit_end = (baud == BAUD_LAST);
  assign ready   = (state == IDLE) && !rst;
  assign busy    = (state != IDLE);

  // State register. tx is registered from the next-state view so the line
  // changes in the same cycle the state does, without combinational glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      baud  <= '0;
      bitc  <= '0;
      shreg <= '0;
      par   <= 1'b0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      baud  <= baud_n;
      bitc  <= bitc_n;
      shreg <= shreg_n;
      par   <= par_n;
      tx    <= tx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    bitc_n  = bitc;
    shreg_n = shreg;
    par_n   = par;
    // Baud counter only runs inside a frame and wraps at each bit boundary.
    if (state == IDLE || bit_end) baud_n = '0;
    else                          baud_n = baud + 1'b1;
    case (state)
      IDLE: begin
        if (valid && ready) begin
          state_n = START;
          shreg_n = data;
          par_n   = (^data) ^ (PARITY_ODD != 0);
          bitc_n  = '0;
        end
      end
      START: if (bit_end) state_n = DATA;
      DATA: begin
        if (bit_end) begin
          shreg_n = shreg >> 1;
          if (bitc == DATA_LAST) begin
            bitc_n  = '0;
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bitc_n = bitc + 1'b1;
          end
        end
      end
      PARITY: if (bit_end) state_n = STOP;
      STOP: begin
        if (bit_end) begin
          if (bitc == STOP_LAST) begin
            bitc_n  = '0;
            state_n = IDLE;
          end else begin
            bitc_n = bitc + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output logic: line level for the state being entered
  always_comb begin
    tx_d = 1'b1;
    case (state_n)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_n[0];
      PARITY:  tx_d = par_n;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx with default parameters. A frame-position model predicts
// tx/busy/ready every cycle; directed literal checks pin the model.
module tb_uart_tx;

  localparam int R   = 400;
  localparam int DW  = 8;
  localparam int PEN = 1;
  localparam int POD = 1;
  localparam int SB  = 1;
  localparam int F   = R * (1 + DW + PEN + SB);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic [DW-1:0] data = '0;
  logic          ready, tx, busy;

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx #(
    .CLOCK_BAUD_RATIO(R), .DATA_WIDTH(DW), .PARITY_EN(PEN),
    .PARITY_ODD(POD), .STOP_BITS(SB)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready),
    .data(data), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: pos = cycle index inside the current frame, -1 when idle.
  int            pos = -1;
  int            cyc = 0;
  logic [DW-1:0] mdata = '0;
  logic          m_acc = 1'b0;

  function automatic logic frame_bit(input logic [DW-1:0] d, input int p);
    int  b;
    logic even_ones;
    b = p / R;
    even_ones = ($countones(d) % 2) == 0;
    if (b == 0)                      return 1'b0;
    if (b <= DW)                     return d[b-1];
    if (PEN != 0 && b == DW + 1)     return (POD != 0) ? even_ones : !even_ones;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    m_acc = 1'b0;
    cyc++;
    if (rst) pos = -1;
    else if (pos < 0) begin
      if (valid) begin
        mdata = data;
        pos   = 0;
        m_acc = 1'b1;
      end
    end else begin
      pos++;
      if (pos == F) pos = -1;
    end
  end

  // Per-cycle compare against the model
  always @(posedge clk) begin
    logic etx, ebusy, erdy;
    #2;
    etx   = (pos < 0) ? 1'b1 : frame_bit(mdata, pos);
    ebusy = (pos >= 0);
    erdy  = (pos < 0) && !rst;
    n_cmp += 3;
    if (tx !== etx) begin
      n_bad++;
      $display("FAIL tx cyc=%0d pos=%0d got=%b want=%b", cyc, pos, tx, etx);
    end
    if (busy !== ebusy) begin
      n_bad++;
      $display("FAIL busy cyc=%0d pos=%0d got=%b want=%b", cyc, pos, busy, ebusy);
    end
    if (ready !== erdy) begin
      n_bad++;
      $display("FAIL ready cyc=%0d pos=%0d got=%b want=%b", cyc, pos, ready, erdy);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_acc(output int t);
    bit ok = 0;
    t = -1;
    for (int i = 0; i < 3 * F && !ok; i++) begin
      edge1();
      if (m_acc) begin
        ok = 1;
        t  = cyc;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic send(input logic [DW-1:0] d, output int t);
    valid = 1'b1;
    data  = d;
    wait_acc(t);
    valid = 1'b0;
  endtask

  task automatic to_pos(input int p);
    for (int i = 0; i < F + 2 && pos >= 0 && pos < p; i++) edge1();
    chk("reach_pos", pos, p);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < F + 2 && pos >= 0; i++) edge1();
    chk("idle_timeout", pos, -1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t1, t2;
    logic [10:0] pat33;

    // Reset held 3 cycles with valid high
    rst = 1'b1; valid = 1'b1; data = 8'hAB;
    repeat (3) begin
      edge1();
      chk("rst_ready", ready, 0);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
    end
    rst = 1'b0; valid = 1'b0;
    edge1();
    chk("ready_after_rst", ready, 1);

    // Single 0x33 frame, bit levels and ready return time
    pat33 = 11'b11001100110;
    send(8'h33, t);
    for (int b = 0; b < 11; b++) begin
      to_pos(b * R + R / 2);
      chk($sformatf("f33_bit%0d", b), tx, pat33[b]);
    end
    to_pos(F - 1);
    chk("f33_ready_late", ready, 0);
    edge1();
    chk("f33_ready_back", ready, 1);

    // Back-to-back 0x00 then 0xFF with valid held
    valid = 1'b1; data = 8'h00;
    wait_acc(t1);
    data = 8'hFF;
    to_pos(9 * R + R / 2);
    chk("b2b_par0", tx, 1);
    wait_acc(t2);
    valid = 1'b0;
    chk("b2b_period", t2 - t1, F + 1);
    to_pos(R + R / 2);
    chk("b2b_ff_bit0", tx, 1);
    to_pos(9 * R + R / 2);
    chk("b2b_par1", tx, 1);
    wait_idle();

    // valid pulse mid-DATA is ignored
    send(8'h3C, t);
    to_pos(3 * R + 50);
    valid = 1'b1; data = 8'h12;
    edge1();
    chk("ign_ready", ready, 0);
    chk("ign_busy", busy, 1);
    valid = 1'b0;
    to_pos(5 * R + 200);
    chk("ign_bit4", tx, 1);
    wait_idle();

    // Reset during bit 3, then a clean 0x55
    send(8'hC3, t);
    to_pos(3 * R + 100);
    rst = 1'b1;
    edge1();
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", ready, 0);
    rst = 1'b0;
    edge1();
    chk("mid_rst_ready_back", ready, 1);
    send(8'h55, t);
    to_pos(R + R / 2);
    chk("f55_bit0", tx, 1);
    to_pos(2 * R + R / 2);
    chk("f55_bit1", tx, 0);
    to_pos(9 * R + R / 2);
    chk("f55_par", tx, 1);
    wait_idle();

    // Random frames, gaps, ignored data changes and occasional aborts
    for (int n = 0; n < 5; n++) begin
      repeat ($urandom_range(0, 30)) edge1();
      send(8'($urandom), t);
      valid = 1'b1;
      data  = 8'($urandom);
      repeat ($urandom_range(0, 5)) edge1();
      valid = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        to_pos($urandom_range(10, F - 2));
        rst = 1'b1;
        edge1();
        rst = 1'b0;
      end
      wait_idle();
    end
    repeat (3) edge1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
